fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage and IF/ID pipeline register feeding the decode control block. Holds the PC, drives the instruction-memory address, captures fetched instructions with their PC+2, and inserts bubbles on memory stalls, redirects, and halts. Consumes the decoder's `Halt` and the later-stage redirect, closing the loop between the instruction stream and its decode.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `NOP_INSTR`, 16'h0800, bubble instruction (opcode 5'b00001, NOP) placed in IF/ID.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_addr`  out  16  instruction-memory address; combinational copy of PC.
- `imem_rdata`  in  16  instruction word at `imem_addr`, valid the same cycle unless `imem_stall`.
- `imem_stall`  in  1  memory not ready; `imem_rdata` is invalid this cycle.
- `stall`  in  1  hazard hold from decode; freeze PC and IF/ID.
- `flush`  in  1  redirect from a later stage (branch/jump resolved taken).
- `redirect_pc`  in  16  target PC, sampled when `flush`=1.
- `halt`  in  1  decoder `Halt` for the instruction currently in IF/ID.
- `instr_out`  out  16  IF/ID instruction; bits [15:11] drive decode `Instr`.
- `pc_plus2_out`  out  16  IF/ID PC+2 of `instr_out`, used for link/branch.
- `valid_out`  out  1  IF/ID holds a real instruction.
- `halted`  out  1  fetch stopped by HALT.

## Operation
- State machine: RUN, HALTED. Reset → RUN.
- Per-cycle priority in RUN: `flush` > `halt` (qualified) > `stall` > `imem_stall` > advance.
  - flush: PC←`redirect_pc`; IF/ID←{`NOP_INSTR`, PC+2 don't-care held at 0, valid 0}.
  - halt: effective only when `valid_out`=1 and `stall`=0. PC holds; IF/ID←bubble; state→HALTED.
  - stall: PC and IF/ID hold (including `valid_out`).
  - imem_stall: PC holds; IF/ID←bubble.
  - advance: IF/ID←{`imem_rdata`, PC+2, valid 1}; PC←PC+2.
- HALTED: PC frozen; IF/ID held at bubble; `halted`=1; `stall`, `imem_stall`, `halt` ignored. `flush` still taken (PC←`redirect_pc`, state→RUN). Only `flush` or `rst` leaves HALTED.
- Arithmetic: PC+2 is 16-bit, wraps 16'hFFFE → 16'h0000, no carry out. PC bit 0 not forced; `redirect_pc` used verbatim.
- `halt` while `valid_out`=0 is ignored (bubbles never halt).

## Timing
- Reset values: PC=`RESET_PC`, `imem_addr`=`RESET_PC`, `instr_out`=`NOP_INSTR`, `pc_plus2_out`=0, `valid_out`=0, `halted`=0.
- First real instruction appears on `instr_out` one edge after `rst` deasserts (if `imem_stall`=0).
- Fetch latency: address presented cycle N → `instr_out` valid after edge ending cycle N.
- Redirect penalty: `flush` in cycle N → cycle N+1 shows bubble while fetching `redirect_pc`; target instruction in IF/ID after edge ending N+1.
- Halt: `halt` sampled in cycle N → `halted`=1 and bubble from cycle N+1; the following fetched word is discarded.
- `rst` asserted mid-stall, mid-halt, or mid-flush: all state returns to reset values immediately (async); no partial update.
- `stall` with `imem_stall`: stall wins; IF/ID content preserved, not bubbled.

## Structure
- Shared package: `NOP_INSTR`, `RESET_PC` default, fetch state enum {RUN, HALTED}, instruction width 16.
- One sub-module: `if_id_reg`, the IF/ID register with hold, bubble-load and normal-load controls; state machine and PC stay in `fetch_unit`.

## Test plan
- Reset then 4 cycles, imem returns 16'hC001,16'hD002,16'hE003,16'hF004 at 0,2,4,6 → `instr_out` sequence matches, `pc_plus2_out`=2,4,6,8, `valid_out`=1 from cycle 1.
- `imem_stall` for 2 cycles at PC=4 → two bubbles (16'h0800, valid 0), PC held at 4, then 16'hE003 with `pc_plus2_out`=6.
- `stall` and `imem_stall` together for 3 cycles → IF/ID unchanged, `valid_out` stays 1, PC unchanged.
- `flush` with `redirect_pc`=16'h0100 concurrent with `halt`=1 → no halt; next cycle bubble; then instruction at 16'h0100 with `pc_plus2_out`=16'h0102.
- `halt`=1 with `valid_out`=1 → `halted`=1, PC frozen, bubbles; `halt` with `valid_out`=0 ignored; `flush` to 16'h0020 in HALTED resumes at 16'h0020; `rst` while halted → `halted`=0, PC=`RESET_PC`.
- PC=16'hFFFE advance → PC wraps to 16'h0000, `pc_plus2_out`=16'h0000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package fetch_unit_pkg;

  localparam int          INSTR_W          = 16;
  localparam logic [15:0] NOP_INSTR        = 16'h0800;  // opcode 5'b00001
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // IF/ID pipeline register contents
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [15:0]        pc_plus2;
    logic               vld;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc_plus2: 16'h0000, vld: 1'b0};

  // Sequential PC step; 16-bit wrap, carry discarded
  function automatic logic [15:0] pc_step(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register with hold, bubble-load and normal-load controls.
// Latency: one cycle from load/bubble to output.
// Backpressure: holds contents whenever neither load nor bubble is asserted.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  bubble,
  input  ifid_t din,
  output ifid_t q
);

  // Bubble beats load; neither means hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= IFID_BUBBLE;
    end else if (bubble) begin
      q <= IFID_BUBBLE;
    end else if (load) begin
      q <= din;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, imem addressing, IF/ID register, halt/redirect handling.
// Latency: address in cycle N -> instr_out after the edge ending cycle N.
// Backpressure: stall freezes PC and IF/ID; imem_stall freezes PC and inserts bubbles.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_stall,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic [15:0] instr_out,
  output logic [15:0] pc_plus2_out,
  output logic        valid_out,
  output logic        halted
);

  fetch_state_t state;
  logic [15:0]  pc;
  logic [15:0]  pc_next_seq;
  logic         halt_take;
  logic         ifid_load;
  logic         ifid_bubble;
  ifid_t        ifid_din;
  ifid_t        ifid_q;

  assign imem_addr   = pc;
  assign pc_next_seq = pc_step(pc);

  // A halt is only honoured for a real instruction that is not being held by decode
  assign halt_take = halt & ifid_q.vld & ~stall;

  assign ifid_din = '{instr: imem_rdata, pc_plus2: pc_next_seq, vld: 1'b1};

  // IF/ID control, priority flush > halt > stall > imem_stall > advance
  always_comb begin
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    if (state == RUN) begin
      if (flush || halt_take) begin
        ifid_bubble = 1'b1;
      end else if (stall) begin
        ifid_bubble = 1'b0;
      end else if (imem_stall) begin
        ifid_bubble = 1'b1;
      end else begin
        ifid_load = 1'b1;
      end
    end else begin
      // HALTED keeps a bubble in IF/ID regardless of flush
      ifid_bubble = 1'b1;
    end
  end

  // Fetch FSM and PC; halted is a registered copy of the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else if (state == RUN) begin
      if (flush) begin
        pc <= redirect_pc;
      end else if (halt_take) begin
        state  <= HALTED;
        halted <= 1'b1;
      end else if (!stall && !imem_stall) begin
        pc <= pc_next_seq;
      end
    end else begin
      if (flush) begin
        pc     <= redirect_pc;
        state  <= RUN;
        halted <= 1'b0;
      end
    end
  end

  if_id_reg u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .din    (ifid_din),
    .q      (ifid_q)
  );

  assign instr_out    = ifid_q.instr;
  assign pc_plus2_out = ifid_q.pc_plus2;
  assign valid_out    = ifid_q.vld;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a cycle-level behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_stall;
  logic        stall;
  logic        flush;
  logic [15:0] redirect_pc;
  logic        halt;
  logic [15:0] instr_out;
  logic [15:0] pc_plus2_out;
  logic        valid_out;
  logic        halted;

  int tests = 0;
  int fails = 0;

  // Behavioural model of the architecturally visible state
  logic [15:0] m_pc;
  logic [15:0] m_instr;
  logic [15:0] m_pp2;
  logic        m_vld;
  logic        m_halted;

  always #5 clk = ~clk;

  // Instruction memory contents: fixed words at 0..6, a scrambled pattern elsewhere
  function automatic logic [15:0] memword(input logic [15:0] a);
    case (a)
      16'h0000: return 16'hC001;
      16'h0002: return 16'hD002;
      16'h0004: return 16'hE003;
      16'h0006: return 16'hF004;
      default:  return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3} + 16'h1234;
    endcase
  endfunction

  assign imem_rdata = memword(imem_addr);

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_stall   (imem_stall),
    .stall        (stall),
    .flush        (flush),
    .redirect_pc  (redirect_pc),
    .halt         (halt),
    .instr_out    (instr_out),
    .pc_plus2_out (pc_plus2_out),
    .valid_out    (valid_out),
    .halted       (halted)
  );

  task automatic model_reset();
    m_pc     = 16'h0000;
    m_instr  = 16'h0800;
    m_pp2    = 16'h0000;
    m_vld    = 1'b0;
    m_halted = 1'b0;
  endtask

  task automatic model_bubble();
    m_instr = 16'h0800;
    m_pp2   = 16'h0000;
    m_vld   = 1'b0;
  endtask

  // One clock of the fetch rules, applied to the current inputs
  task automatic model_clock();
    if (m_halted) begin
      if (flush) begin
        m_pc     = redirect_pc;
        m_halted = 1'b0;
      end
    end else if (flush) begin
      m_pc = redirect_pc;
      model_bubble();
    end else if (halt && m_vld && !stall) begin
      m_halted = 1'b1;
      model_bubble();
    end else if (stall) begin
      // everything holds
    end else if (imem_stall) begin
      model_bubble();
    end else begin
      m_instr = memword(m_pc);
      m_pp2   = m_pc + 16'd2;
      m_vld   = 1'b1;
      m_pc    = m_pc + 16'd2;
    end
  endtask

  task automatic set_in(input logic f, input logic [15:0] rp, input logic h,
                        input logic s, input logic is);
    flush = f; redirect_pc = rp; halt = h; stall = s; imem_stall = is;
  endtask

  // Clock once; outputs are sampled 1 time unit after the rising edge
  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    set_in(0, 16'h0, 0, 0, 0);
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 16'h0, 0, 0, 0);
    model_reset();
    #1;
    tests++;
    if ({imem_addr, instr_out, pc_plus2_out, valid_out, halted} !== {16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_values: got addr=%h instr=%h pp2=%h vld=%b halted=%b",
               imem_addr, instr_out, pc_plus2_out, valid_out, halted);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if ({imem_addr, valid_out} !== {16'h0000, 1'b0}) begin
      fails++;
      $display("FAIL reset_release: got addr=%h vld=%b want 0000/0", imem_addr, valid_out);
    end
  endtask

  task automatic test_sequence();
    logic [15:0] exp_i [4];
    logic [15:0] exp_p [4];
    exp_i = '{16'hC001, 16'hD002, 16'hE003, 16'hF004};
    exp_p = '{16'h0002, 16'h0004, 16'h0006, 16'h0008};
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if ({instr_out, pc_plus2_out, valid_out} !== {exp_i[i], exp_p[i], 1'b1}) begin
        fails++;
        $display("FAIL seq_%0d: got instr=%h pp2=%h vld=%b want %h/%h/1",
                 i, instr_out, pc_plus2_out, valid_out, exp_i[i], exp_p[i]);
      end
    end
  endtask

  task automatic test_imem_stall();
    do_reset();
    step();
    step();
    set_in(0, 16'h0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if ({imem_addr, instr_out, valid_out} !== {16'h0004, 16'h0800, 1'b0}) begin
        fails++;
        $display("FAIL imem_stall_%0d: got addr=%h instr=%h vld=%b want 0004/0800/0",
                 i, imem_addr, instr_out, valid_out);
      end
    end
    set_in(0, 16'h0, 0, 0, 0);
    step();
    tests++;
    if ({instr_out, pc_plus2_out, valid_out} !== {16'hE003, 16'h0006, 1'b1}) begin
      fails++;
      $display("FAIL imem_stall_resume: got instr=%h pp2=%h vld=%b want E003/0006/1",
               instr_out, pc_plus2_out, valid_out);
    end
  endtask

  task automatic test_stall_both();
    logic [15:0] a0, i0, p0;
    a0 = imem_addr; i0 = instr_out; p0 = pc_plus2_out;
    set_in(0, 16'h0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({imem_addr, instr_out, pc_plus2_out, valid_out} !== {16'h0006, 16'hE003, 16'h0006, 1'b1}) begin
        fails++;
        $display("FAIL stall_both_%0d: got addr=%h instr=%h pp2=%h vld=%b want 0006/E003/0006/1 (was %h/%h/%h)",
                 i, imem_addr, instr_out, pc_plus2_out, valid_out, a0, i0, p0);
      end
    end
    set_in(0, 16'h0, 0, 0, 0);
  endtask

  task automatic test_flush_halt();
    // IF/ID is valid here, so only the flush priority prevents the halt
    set_in(1, 16'h0100, 1, 0, 0);
    step();
    tests++;
    if ({imem_addr, instr_out, valid_out, halted} !== {16'h0100, 16'h0800, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL flush_halt: got addr=%h instr=%h vld=%b halted=%b want 0100/0800/0/0",
               imem_addr, instr_out, valid_out, halted);
    end
    set_in(0, 16'h0, 0, 0, 0);
    step();
    tests++;
    if ({instr_out, pc_plus2_out, valid_out} !== {memword(16'h0100), 16'h0102, 1'b1}) begin
      fails++;
      $display("FAIL flush_target: got instr=%h pp2=%h vld=%b want %h/0102/1",
               instr_out, pc_plus2_out, valid_out, memword(16'h0100));
    end
  endtask

  task automatic test_halt();
    logic [15:0] frozen;
    do_reset();
    step();
    step();
    frozen = imem_addr;
    set_in(0, 16'h0, 1, 0, 0);
    step();
    tests++;
    if ({halted, imem_addr, instr_out, valid_out} !== {1'b1, 16'h0004, 16'h0800, 1'b0}) begin
      fails++;
      $display("FAIL halt_enter: got halted=%b addr=%h instr=%h vld=%b want 1/0004/0800/0",
               halted, imem_addr, instr_out, valid_out);
    end
    for (int i = 0; i < 3; i++) begin
      set_in(0, 16'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step();
      tests++;
      if ({halted, imem_addr, valid_out} !== {1'b1, frozen, 1'b0}) begin
        fails++;
        $display("FAIL halt_hold_%0d: got halted=%b addr=%h vld=%b want 1/%h/0",
                 i, halted, imem_addr, valid_out, frozen);
      end
    end
    set_in(1, 16'h0020, 0, 0, 0);
    step();
    tests++;
    if ({halted, imem_addr, valid_out} !== {1'b0, 16'h0020, 1'b0}) begin
      fails++;
      $display("FAIL halt_flush: got halted=%b addr=%h vld=%b want 0/0020/0", halted, imem_addr, valid_out);
    end
    // halt against a bubble must be ignored
    set_in(0, 16'h0, 1, 0, 0);
    step();
    tests++;
    if ({halted, instr_out, pc_plus2_out, valid_out} !== {1'b0, memword(16'h0020), 16'h0022, 1'b1}) begin
      fails++;
      $display("FAIL halt_on_bubble: got halted=%b instr=%h pp2=%h vld=%b want 0/%h/0022/1",
               halted, instr_out, pc_plus2_out, valid_out, memword(16'h0020));
    end
    step();
    tests++;
    if (halted !== 1'b1) begin
      fails++;
      $display("FAIL halt_again: got halted=%b want 1", halted);
    end
    // asynchronous reset while halted, checked before any clock edge
    rst = 1'b1;
    model_reset();
    #1;
    tests++;
    if ({halted, imem_addr, instr_out, pc_plus2_out, valid_out} !== {1'b0, 16'h0000, 16'h0800, 16'h0000, 1'b0}) begin
      fails++;
      $display("FAIL halt_rst: got halted=%b addr=%h instr=%h pp2=%h vld=%b",
               halted, imem_addr, instr_out, pc_plus2_out, valid_out);
    end
    set_in(0, 16'h0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    set_in(1, 16'hFFFE, 0, 0, 0);
    step();
    set_in(0, 16'h0, 0, 0, 0);
    step();
    tests++;
    if ({imem_addr, instr_out, pc_plus2_out, valid_out} !== {16'h0000, memword(16'hFFFE), 16'h0000, 1'b1}) begin
      fails++;
      $display("FAIL wrap: got addr=%h instr=%h pp2=%h vld=%b want 0000/%h/0000/1",
               imem_addr, instr_out, pc_plus2_out, valid_out, memword(16'hFFFE));
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      set_in($urandom_range(0, 9) == 0, 16'($urandom), $urandom_range(0, 5) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
      step();
      tests++;
      if ({imem_addr, instr_out, pc_plus2_out, valid_out, halted} !== {m_pc, m_instr, m_pp2, m_vld, m_halted}) begin
        fails++;
        $display("FAIL random_%0d: got addr=%h instr=%h pp2=%h vld=%b halted=%b want %h/%h/%h/%b/%b",
                 i, imem_addr, instr_out, pc_plus2_out, valid_out, halted,
                 m_pc, m_instr, m_pp2, m_vld, m_halted);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_imem_stall();
    test_stall_both();
    test_flush_halt();
    test_halt();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
